// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl_pkg
// Description : Shared size codes, FSM encodings and alignment helper for the
//               MEM-stage data bus controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // The illegal size code is handled exactly like a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic r;
        case (size)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = addr_lo[0];
            default: r = (addr_lo != 2'b00);
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_lane.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_unit
// Description : Combinational byte-lane logic: big-endian select/store-data
//               generation and load lane extraction with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_unit
    import mem_access_ctrl_pkg::*;
(
    input  logic [1:0]  i_req_size,
    input  logic [1:0]  i_req_addr_lo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_sel,
    output logic [31:0] o_wdata,
    output logic        o_misaligned,
    input  logic [1:0]  i_rsp_size,
    input  logic [1:0]  i_rsp_addr_lo,
    input  logic        i_rsp_signed,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign o_misaligned = is_misaligned(i_req_size, i_req_addr_lo);

    always_comb begin
        o_sel   = 4'b1111;
        o_wdata = i_wdata;
        case (i_req_size)
            SZ_BYTE: begin
                o_sel   = 4'b1000 >> i_req_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_sel   = i_req_addr_lo[1] ? 4'b0011 : 4'b1100;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_sel   = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

    // Big-endian: byte offset 0 lives in the most significant lane.
    always_comb begin
        w_byte = i_rdata[31:24];
        case (i_rsp_addr_lo)
            2'd0:    w_byte = i_rdata[31:24];
            2'd1:    w_byte = i_rdata[23:16];
            2'd2:    w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    assign w_half = i_rsp_addr_lo[1] ? i_rdata[15:0] : i_rdata[31:16];

    always_comb begin
        o_rdata = i_rdata;
        case (i_rsp_size)
            SZ_BYTE: o_rdata = {{24{i_rsp_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_rdata = {{16{i_rsp_signed & w_half[15]}}, w_half};
            default: o_rdata = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Sequences MEM-stage loads/stores onto a registered
//               Wishbone-style bus with wait states, timeout and flush drain.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_signed_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        flush_i,
    output logic [31:0] mem_rdata_o,
    output logic        done_o,
    output logic        stall_req_o,
    output logic        align_err_o,
    output logic        bus_err_o,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [TO_W-1:0] r_cnt;

    logic            r_cyc;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [3:0]      r_sel;
    logic [31:0]     r_wdata;
    logic [31:0]     r_mem_rdata;
    logic            r_bus_err;
    logic [1:0]      r_size;
    logic [1:0]      r_addr_lo;
    logic            r_signed;

    logic [3:0]      w_sel;
    logic [31:0]     w_wdata;
    logic            w_misaligned;
    logic [31:0]     w_lane_rdata;

    logic            w_idle;
    logic            w_busy;
    logic            w_done;
    logic            w_drain;
    logic            w_active;
    logic            w_accept;
    logic            w_align_err;
    logic            w_timeout;
    logic            w_bus_end;
    logic            w_load_done;
    logic            w_err_set;

    mem_lane_unit u_lane (
        .i_req_size    (mem_size_i),
        .i_req_addr_lo (mem_addr_i[1:0]),
        .i_wdata       (mem_wdata_i),
        .o_sel         (w_sel),
        .o_wdata       (w_wdata),
        .o_misaligned  (w_misaligned),
        .i_rsp_size    (r_size),
        .i_rsp_addr_lo (r_addr_lo),
        .i_rsp_signed  (r_signed),
        .i_rdata       (bus_rdata_i),
        .o_rdata       (w_lane_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = ST_BUSY;
            end
            ST_BUSY: begin
                // A flush that coincides with ack simply ends the cycle silently.
                if (bus_ack_i)      w_next = flush_i ? ST_IDLE : ST_DONE;
                else if (w_timeout) w_next = ST_IDLE;
                else if (flush_i)   w_next = ST_DRAIN;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            ST_DRAIN: begin
                if (w_bus_end) w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_idle      = (r_state == ST_IDLE);
        w_busy      = (r_state == ST_BUSY);
        w_done      = (r_state == ST_DONE);
        w_drain     = (r_state == ST_DRAIN);
        w_active    = w_busy | w_drain;
        w_accept    = ~rst & w_idle & mem_req_i & ~flush_i & ~w_misaligned;
        w_align_err = ~rst & w_idle & mem_req_i & ~flush_i & w_misaligned;
        w_timeout   = w_active & ~bus_ack_i & (r_cnt == c_to_last);
        w_bus_end   = w_active & (bus_ack_i | w_timeout);
        w_load_done = w_busy & bus_ack_i & ~flush_i & ~r_we;
        w_err_set   = w_busy & w_timeout & ~flush_i;
        stall_req_o = w_accept | (~rst & w_active);
        done_o      = ~rst & w_done & ~flush_i;
        align_err_o = w_align_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= ZERO_WORD;
            r_sel       <= 4'b0000;
            r_wdata     <= ZERO_WORD;
            r_mem_rdata <= ZERO_WORD;
            r_bus_err   <= 1'b0;
            r_size      <= SZ_BYTE;
            r_addr_lo   <= 2'b00;
            r_signed    <= 1'b0;
        end else begin
            r_bus_err <= w_err_set;
            if (w_accept) begin
                r_cnt     <= '0;
                r_cyc     <= 1'b1;
                r_we      <= mem_we_i;
                r_addr    <= {mem_addr_i[31:2], 2'b00};
                r_sel     <= w_sel;
                r_wdata   <= w_wdata;
                r_size    <= mem_size_i;
                r_addr_lo <= mem_addr_i[1:0];
                r_signed  <= mem_signed_i;
            end else if (w_bus_end) begin
                r_cyc <= 1'b0;
                r_we  <= 1'b0;
                r_sel <= 4'b0000;
            end else if (w_active) begin
                r_cnt <= r_cnt + TO_W'(1);
            end
            if (w_load_done) begin
                r_mem_rdata <= w_lane_rdata;
            end
        end
    end

    assign mem_rdata_o = r_mem_rdata;
    assign bus_err_o   = r_bus_err;
    assign bus_cyc_o   = r_cyc;
    assign bus_stb_o   = r_cyc;
    assign bus_we_o    = r_we;
    assign bus_addr_o  = r_addr;
    assign bus_sel_o   = r_sel;
    assign bus_wdata_o = r_wdata;

endmodule
`default_nettype wire
